// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared definitions for the program-counter / instruction-fetch block.
//   state_e          : fetch sequencer states
//   INSTR_BYTES      : size of one instruction word in bytes (PC increment)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   is_word_aligned  : helper, true when a byte address is word aligned
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_TRAP = 2'd3
    } state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word alignment only looks at the two byte-offset bits.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC selection.
//   pc        (in)  : address of the instruction currently held
//   pc_branch (in)  : branch target address
//   taken     (in)  : branch resolved taken (already qualified by the caller)
//   next_pc   (out) : pc + INSTR_BYTES (wrapping mod 2^32) or pc_branch
//   misalign  (out) : taken branch whose target is not word aligned
// When misalign is set the caller must not load next_pc.
// -----------------------------------------------------------------------------
module pc_next_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_branch,
    input  logic        taken,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] seq_pc;

    // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
    assign seq_pc   = pc + 32'(INSTR_BYTES);
    assign next_pc  = taken ? pc_branch : seq_pc;
    assign misalign = taken && !is_word_aligned(pc_branch);

endmodule : pc_next_sel

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Program counter and instruction-fetch sequencer.
// Issues one instruction-memory read at a time, holds the returned word until
// downstream acknowledges it, then advances the PC (sequential or branch).
// A taken branch to a non-word-aligned target parks the block in a sticky
// trap state until reset.
//
// Ports
//   clk         (in)  : clock, rising edge
//   rst_n       (in)  : synchronous active-low reset
//   pc_branch   (in)  : branch target address
//   branch      (in)  : current instruction is a conditional branch
//   zero_flag   (in)  : ALU zero result for the current instruction
//   imem_req    (out) : instruction-memory read request
//   imem_addr   (out) : instruction-memory byte address
//   imem_ready  (in)  : memory accept / data-return strobe
//   imem_rdata  (in)  : read data, valid with imem_ready
//   instr       (out) : held instruction word
//   instr_valid (out) : instr and pc are valid
//   instr_ack   (in)  : downstream consumed instr this cycle
//   pc          (out) : address of the held instruction
//   misalign    (out) : sticky misaligned-branch-target trap flag
//
// All outputs come straight from registers or from a decode of the state
// register, so there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_branch,
    input  logic        branch,
    input  logic        zero_flag,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic [31:0] pc,
    output logic        misalign
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic        valid_q,    valid_d;
    logic        misalign_q, misalign_d;

    // -------------------------------------------------------------------------
    // Next-PC selection
    // -------------------------------------------------------------------------
    logic        consume;
    logic        taken;
    logic [31:0] sel_next_pc;
    logic        sel_misalign;

    // Branch inputs only matter in the single cycle where the held
    // instruction is consumed; everywhere else they are masked off here.
    assign consume = (state_q == ST_HOLD) && instr_ack;
    assign taken   = consume && branch && zero_flag;

    pc_next_sel u_pc_next_sel (
        .pc        (pc_q),
        .pc_branch (pc_branch),
        .taken     (taken),
        .next_pc   (sel_next_pc),
        .misalign  (sel_misalign)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                // Address and request are held until the memory strobes.
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    pc_d    = fetch_pc_q;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (consume) begin
                    valid_d = 1'b0;
                    if (sel_misalign) begin
                        // fetch_pc is left untouched so the faulting
                        // context stays visible.
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        fetch_pc_d = sel_next_pc;
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_TRAP: begin
                valid_d    = 1'b0;
                misalign_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign misalign    = misalign_q;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Directed, self-checking bench for pc_fetch. A queue holds the fetch
// addresses the bench expects the DUT to request; each request pops one entry.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_branch;
    logic        branch;
    logic        zero_flag;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [31:0] pc;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_branch   (pc_branch),
        .branch      (branch),
        .zero_flag   (zero_flag),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .pc          (pc),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are an address-dependent pattern; data is junk unless
    // the memory strobes ready.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    always_comb begin
        imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One complete fetch: wait for request, check address, optionally stall
    // the memory and the consumer, then consume with the given branch inputs
    // and push the address the bench expects next.
    task automatic run_fetch(input int ready_wait, input int ack_wait,
                             input logic br, input logic zf, input logic [31:0] tgt);
        logic [31:0] ea;
        int n;
        n = 0;
        imem_ready = 1'b0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
        chk("sb_depth", exp_q.size(), 32'd1);
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        chk("imem_addr", imem_addr, ea);
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            chk("req_stable", {31'b0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, ea);
            chk("no_valid_wait", {31'b0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b1;   // ignored outside REQ
        chk("valid_1cyc", {31'b0, instr_valid}, 32'd1);
        chk("pc", pc, ea);
        chk("instr", instr, mem_word(ea));
        chk("req_low_hold", {31'b0, imem_req}, 32'd0);
        // Stall the consumer with branch inputs that would trap if sampled.
        for (int i = 0; i < ack_wait; i++) begin
            instr_ack = 1'b0;
            branch    = 1'b1;
            zero_flag = 1'b1;
            pc_branch = 32'h0000_0003;
            tick();
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_pc", pc, ea);
            chk("hold_instr", instr, mem_word(ea));
            chk("hold_noreq", {31'b0, imem_req}, 32'd0);
        end
        instr_ack = 1'b1;
        branch    = br;
        zero_flag = zf;
        pc_branch = tgt;
        tick();
        instr_ack  = 1'b0;
        branch     = 1'b1;
        zero_flag  = 1'b1;
        pc_branch  = 32'h0000_0001;
        imem_ready = 1'b0;
        chk("valid_drop", {31'b0, instr_valid}, 32'd0);
        if (br && zf && (tgt[1:0] != 2'b00)) begin
            chk("trap_misalign", {31'b0, misalign}, 32'd1);
            chk("trap_noreq", {31'b0, imem_req}, 32'd0);
        end else begin
            chk("no_misalign", {31'b0, misalign}, 32'd0);
            exp_q.push_back((br && zf) ? tgt : ea + 32'd4);
        end
        $display("fetch addr=%h br=%0d zf=%0d tgt=%h", ea, br, zf, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        pc_branch  = 32'h0;
        branch     = 1'b0;
        zero_flag  = 1'b0;
        imem_ready = 1'b1;
        instr_ack  = 1'b1;
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        $display("reset checked");

        // First edge with rst_n high: IDLE -> REQ.
        instr_ack = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        exp_q.push_back(32'h0000_0000);

        // Sequential 0, 4, 8 with zero-wait memory; 8 branches to 0x10.
        run_fetch(0, 0, 1'b0, 1'b1, 32'h0000_0100);
        run_fetch(0, 0, 1'b1, 1'b0, 32'h0000_0200);
        run_fetch(0, 0, 1'b1, 1'b1, 32'h0000_0010);
        // pc=0x10 taken to 0x40, 0x40 back to 0x10, then not taken -> 0x14.
        run_fetch(0, 0, 1'b1, 1'b1, 32'h0000_0040);
        run_fetch(0, 0, 1'b1, 1'b1, 32'h0000_0010);
        run_fetch(0, 0, 1'b1, 1'b0, 32'h0000_0040);
        // 0x14 with memory and consumer stalls, branch to the top of memory.
        run_fetch(3, 2, 1'b1, 1'b1, 32'hFFFF_FFFC);
        // Wraparound: 0xFFFF_FFFC + 4 -> 0.
        run_fetch(0, 0, 1'b0, 1'b0, 32'h0000_0000);
        // 0x0 takes a misaligned branch -> trap.
        run_fetch(0, 0, 1'b1, 1'b1, 32'h0000_0042);
        chk("sb_empty_trap", exp_q.size(), 32'd0);

        for (int i = 0; i < 4; i++) begin
            instr_ack  = i[0];
            imem_ready = 1'b1;
            tick();
            chk("trap_sticky", {31'b0, misalign}, 32'd1);
            chk("trap_req0", {31'b0, imem_req}, 32'd0);
            chk("trap_valid0", {31'b0, instr_valid}, 32'd0);
        end
        $display("trap held");

        // One-cycle reset clears the trap and restarts at RESET_PC.
        instr_ack  = 1'b0;
        imem_ready = 1'b0;
        rst_n      = 1'b0;
        tick();
        chk("rst2_misalign", {31'b0, misalign}, 32'd0);
        chk("rst2_pc", pc, 32'd0);
        chk("rst2_instr", instr, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'd0);
        $display("restart after trap");

        // Reset while in REQ with imem_ready in the same cycle.
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk("abort_valid", {31'b0, instr_valid}, 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_req", {31'b0, imem_req}, 32'd0);
        rst_n = 1'b1;
        tick();           // IDLE with a late ready: must be ignored
        chk("late_ready_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_ready_instr", instr, 32'd0);
        $display("abort on reset");

        exp_q.push_back(32'h0000_0000);
        run_fetch(1, 1, 1'b0, 1'b0, 32'h0000_0000);
        run_fetch(0, 0, 1'b0, 1'b0, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_fetch
